// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order LEGv8 pipeline: ROB entry layout, default
// ROB depth and the controlOOO command encoding.
package ooo_pkg;

   localparam int ROB_DEPTH  = 8;
   localparam int ROB_DATA_W = 64;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic [4:0]            rd;
      logic                  regWrite;
      logic                  isStore;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry_t;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ALLOC,
      CMD_WB,
      CMD_COMMIT,
      CMD_FLUSH
   } commandType_t;

endpackage

// File: rtl/rob_ptr.sv
// Circular-buffer pointer with a wrap bit in the MSB; clear beats increment.
module rob_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/rob_ooo.sv
// Reorder buffer: in-order allocate, out-of-order writeback by tag, in-order
// retire of the head entry, with a flush that discards everything in flight.
module rob_ooo
   import ooo_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int DATA_W = 64,
   parameter int TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [4:0]        alloc_rd,
   input  logic              alloc_regWrite,
   input  logic              alloc_isStore,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [4:0]        commit_rd,
   output logic              commit_regWrite,
   output logic              commit_isStore,
   output logic [DATA_W-1:0] commit_data,
   input  logic              flush,
   output logic [TAG_W:0]    count
);

   logic [TAG_W:0]     head;
   logic [TAG_W:0]     tail;
   logic [TAG_W-1:0]   head_idx;
   logic [TAG_W-1:0]   tail_idx;
   logic               full;
   logic               alloc_fire;
   logic               commit_fire;

   logic [DEPTH-1:0]   busy_vec;
   logic [DEPTH-1:0]   done_vec;
   logic [4:0]         rd_arr   [DEPTH];
   logic [DEPTH-1:0]   regw_vec;
   logic [DEPTH-1:0]   store_vec;
   logic [DATA_W-1:0]  data_arr [DEPTH];

   assign head_idx    = head[TAG_W-1:0];
   assign tail_idx    = tail[TAG_W-1:0];
   assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
   assign alloc_ready = !full;
   assign alloc_tag   = tail_idx;
   assign count       = tail - head;

   assign commit_valid    = busy_vec[head_idx] && done_vec[head_idx];
   assign commit_rd       = rd_arr[head_idx];
   assign commit_regWrite = regw_vec[head_idx];
   assign commit_isStore  = store_vec[head_idx];
   assign commit_data     = data_arr[head_idx];

   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign commit_fire = commit_valid && commit_ready && !flush;

   rob_ptr #(.W(TAG_W + 1)) u_head (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (commit_fire),
      .ptr   (head)
   );

   rob_ptr #(.W(TAG_W + 1)) u_tail (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (alloc_fire),
      .ptr   (tail)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
         localparam logic [TAG_W-1:0] IDX = TAG_W'(gi);

         logic              busy_q,  busy_d;
         logic              done_q,  done_d;
         logic [4:0]        rd_q,    rd_d;
         logic              regw_q,  regw_d;
         logic              store_q, store_d;
         logic [DATA_W-1:0] data_q,  data_d;

         // Later assignments win: writeback, then retire, then allocate, then flush.
         always_comb begin
            busy_d  = busy_q;
            done_d  = done_q;
            rd_d    = rd_q;
            regw_d  = regw_q;
            store_d = store_q;
            data_d  = data_q;
            if (wb_valid && (wb_tag == IDX) && busy_q) begin
               done_d = 1'b1;
               data_d = wb_data;
            end
            if (commit_fire && (head_idx == IDX)) begin
               busy_d = 1'b0;
               done_d = 1'b0;
            end
            if (alloc_fire && (tail_idx == IDX)) begin
               busy_d  = 1'b1;
               done_d  = 1'b0;
               rd_d    = alloc_rd;
               regw_d  = alloc_regWrite;
               store_d = alloc_isStore;
            end
            if (flush) begin
               busy_d = 1'b0;
               done_d = 1'b0;
            end
         end

         // Payload is cleared too so the commit fields read zero under reset.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               rd_q    <= '0;
               regw_q  <= 1'b0;
               store_q <= 1'b0;
               data_q  <= '0;
            end else begin
               busy_q  <= busy_d;
               done_q  <= done_d;
               rd_q    <= rd_d;
               regw_q  <= regw_d;
               store_q <= store_d;
               data_q  <= data_d;
            end
         end

         assign busy_vec[gi]  = busy_q;
         assign done_vec[gi]  = done_q;
         assign rd_arr[gi]    = rd_q;
         assign regw_vec[gi]  = regw_q;
         assign store_vec[gi] = store_q;
         assign data_arr[gi]  = data_q;
      end
   endgenerate

endmodule
